conv1_mul_pipe_hs: RTL and testbench

Parametrised, pipelined integer multiplier with a valid/ready handshake, for the Conv1 datapath. It is the successor to the combinational fixed-width multiplier cores. It adds a configurable pipeline depth, per-operand signedness, backpressure-aware stalling, and a per-beat tag that travels with the data. It sits between the window/weight fetch logic and the accumulator in the conv1 MAC lanes.

---
 rtl/conv1_mul_pipe_hs_if.sv | 28 ++
 rtl/conv1_mul_pipe_hs.sv | 90 +++++++++
 tb/tb_conv1_mul_pipe_hs.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_mul_pipe_hs_if.sv
// Valid/ready handshake bundle between the window/weight fetch logic,
// the conv1 multiplier and the accumulator.
interface conv1_mul_pipe_hs_if #(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int TAG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, din0, din1, in_tag, out_ready,
    input  in_ready, out_valid, dout, out_tag
  );

  modport slave (
    input  in_valid, din0, din1, in_tag, out_ready,
    output in_ready, out_valid, dout, out_tag
  );
endinterface

// File: rtl/conv1_mul_pipe_hs.sv
// Pipelined integer multiplier for the conv1 MAC lanes. Operands are
// extended by one bit (sign or zero), multiplied as signed, and the
// product is truncated or sign-extended to dout_WIDTH. The product is
// formed at the input and carried through NUM_STAGE register slices that
// stall globally; synthesis is free to retime the multiplier across them.
module conv1_mul_pipe_hs #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int TAG_WIDTH   = 4,
  parameter int din0_SIGNED = 0,
  parameter int din1_SIGNED = 0
) (
  input logic               ap_clk,
  input logic               ap_rst_n,
  conv1_mul_pipe_hs_if.slave hs
);

  localparam int PROD_WIDTH = din0_WIDTH + din1_WIDTH + 2;

  logic signed [din0_WIDTH:0]   op_a;
  logic signed [din1_WIDTH:0]   op_b;
  logic signed [PROD_WIDTH-1:0] prod_full;
  logic [dout_WIDTH-1:0]        prod;

  // Instance identifier has no functional effect.
  logic [31:0] unused_id;
  assign unused_id = ID;

  // Extend each operand by one bit so unsigned inputs stay positive.
  always_comb begin
    op_a = {((din0_SIGNED != 0) ? hs.din0[din0_WIDTH-1] : 1'b0), hs.din0};
    op_b = {((din1_SIGNED != 0) ? hs.din1[din1_WIDTH-1] : 1'b0), hs.din1};
  end

  assign prod_full = PROD_WIDTH'(op_a) * PROD_WIDTH'(op_b);

  if (dout_WIDTH <= PROD_WIDTH) begin : g_trunc
    assign prod = prod_full[dout_WIDTH-1:0];
  end else begin : g_sext
    assign prod = {{(dout_WIDTH - PROD_WIDTH){prod_full[PROD_WIDTH-1]}}, prod_full};
  end

  if (NUM_STAGE == 0) begin : g_comb
    // Pure pass-through: no state, so clock and reset are not needed.
    logic [1:0] unused_clk_rst;
    assign unused_clk_rst = {ap_clk, ap_rst_n};

    assign hs.out_valid = hs.in_valid;
    assign hs.in_ready  = hs.out_ready;
    assign hs.dout      = prod;
    assign hs.out_tag   = hs.in_tag;
  end else begin : g_pipe
    logic [NUM_STAGE-1:0]  vld;
    logic [dout_WIDTH-1:0] dat [NUM_STAGE];
    logic [TAG_WIDTH-1:0]  tag [NUM_STAGE];
    logic                  advance;

    // Whole pipe moves together; a held output freezes every slice.
    assign advance = !vld[NUM_STAGE-1] || hs.out_ready;

    // Slice shift register; data is also reset so dout is deterministic.
    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        vld <= '0;
        for (int i = 0; i < NUM_STAGE; i++) begin
          dat[i] <= '0;
          tag[i] <= '0;
        end
      end else if (advance) begin
        vld[0] <= hs.in_valid;
        dat[0] <= prod;
        tag[0] <= hs.in_tag;
        for (int i = 1; i < NUM_STAGE; i++) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
          tag[i] <= tag[i-1];
        end
      end
    end

    assign hs.in_ready  = advance;
    assign hs.out_valid = vld[NUM_STAGE-1];
    assign hs.dout      = dat[NUM_STAGE-1];
    assign hs.out_tag   = tag[NUM_STAGE-1];
  end

endmodule

// File: tb/tb_conv1_mul_pipe_hs.sv
// Bench for conv1_mul_pipe_hs: five instances with different depth,
// signedness and output width share one stimulus; each keeps its own
// scoreboard of expected {tag, product} beats.
module tb_conv1_mul_pipe_hs;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [13:0] din0;
  logic [11:0] din1;
  logic [3:0]  in_tag;
  logic        drain_chk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_u
    localparam int NS = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 6 : (g == 3) ? 0 : 2;
    localparam int S0 = (g == 1 || g == 2 || g == 4) ? 1 : 0;
    localparam int S1 = (g == 1 || g == 4) ? 1 : 0;
    localparam int D  = (g == 3) ? 8 : (g == 4) ? 30 : 26;

    conv1_mul_pipe_hs_if #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(D), .TAG_WIDTH(4)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.din0      = din0;
    assign bus.din1      = din1;
    assign bus.in_tag    = in_tag;
    assign bus.out_ready = out_ready;

    conv1_mul_pipe_hs #(
      .ID(g), .NUM_STAGE(NS), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(D),
      .TAG_WIDTH(4), .din0_SIGNED(S0), .din1_SIGNED(S1)
    ) dut (
      .ap_clk(clk),
      .ap_rst_n(rst_n),
      .hs(bus)
    );

    function automatic logic [D-1:0] ref_mul(input logic [13:0] a, input logic [11:0] b);
      longint sa, sb, p;
      if (S0 != 0) sa = longint'($signed(a)); else sa = longint'(a);
      if (S1 != 0) sb = longint'($signed(b)); else sb = longint'(b);
      p = sa * sb;
      return p[D-1:0];
    endfunction

    logic [D+3:0] q [$];
    logic [D+3:0] e;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        if (bus.in_valid && bus.in_ready) q.push_back({in_tag, ref_mul(din0, din1)});
        if (bus.out_valid && bus.out_ready) begin
          chk($sformatf("u%0d_sb_nonempty", g), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("u%0d_sb_dout", g), 64'(bus.dout), 64'(e[D-1:0]));
            chk($sformatf("u%0d_sb_tag", g), 64'(bus.out_tag), 64'(e[D+3:D]));
          end
        end
      end
    end

    always @(posedge drain_chk) chk($sformatf("u%0d_leftover", g), 64'(q.size()), 64'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  int b;

  initial begin
    drain_chk = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    din0      = 14'd5;
    din1      = 12'd5;
    in_tag    = 4'd1;

    // Reset: beat presented during reset is discarded.
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_u0_out_valid", 64'(g_u[0].bus.out_valid), 64'd0);
    chk("rst_u0_dout", 64'(g_u[0].bus.dout), 64'd0);
    chk("rst_u0_out_tag", 64'(g_u[0].bus.out_tag), 64'd0);
    chk("rst_u0_in_ready", 64'(g_u[0].bus.in_ready), 64'd1);
    chk("rst_u2_out_valid", 64'(g_u[2].bus.out_valid), 64'd0);
    cyc();
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Max unsigned operands, latency 3, one-cycle out_valid.
    cyc();
    in_valid = 1'b1; din0 = 14'h3FFF; din1 = 12'hFFF; in_tag = 4'd5;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      if (k <= 4) chk("t1_u0_out_valid", 64'(g_u[0].bus.out_valid), 64'(k == 3));
      if (k == 3) begin
        chk("t1_u0_dout", 64'(g_u[0].bus.dout), 64'h3FFB001);
        chk("t1_u0_out_tag", 64'(g_u[0].bus.out_tag), 64'd5);
      end
      if (k == 6) chk("t1_u2_mixed_dout", 64'(g_u[2].bus.dout), 64'h3FFF001);
    end
    idle(4);

    // Signed x signed: -3 * 7.
    cyc();
    in_valid = 1'b1; din0 = 14'h3FFD; din1 = 12'd7; in_tag = 4'd2;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_u1_out_valid", 64'(g_u[1].bus.out_valid), 64'(k == 1));
      if (k == 1) begin
        chk("t2_u1_dout", 64'(g_u[1].bus.dout), 64'h3FFFFEB);
        chk("t2_u1_out_tag", 64'(g_u[1].bus.out_tag), 64'd2);
      end
      if (k == 2) chk("t2_u4_sext_dout", 64'(g_u[4].bus.dout), 64'h3FFFFFEB);
    end
    idle(6);

    // Narrow output, combinational instance.
    cyc();
    in_valid = 1'b1; din0 = 14'd200; din1 = 12'd3; in_tag = 4'd7;
    @(negedge clk);
    chk("t3_u3_dout", 64'(g_u[3].bus.dout), 64'h58);
    chk("t3_u3_out_valid", 64'(g_u[3].bus.out_valid), 64'd1);
    chk("t3_u3_out_tag", 64'(g_u[3].bus.out_tag), 64'd7);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_u3_in_ready", 64'(g_u[3].bus.in_ready), 64'd0);
    idle(10);

    // Streaming 16 beats with out_ready low on cycles 5..9.
    b = 0;
    for (int c = 0; c < 25; c++) begin
      cyc();
      out_ready = !(c >= 5 && c <= 9);
      if (b < 16) begin
        in_valid = 1'b1; din0 = 14'(b); din1 = 12'(b + 1); in_tag = 4'(b);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("t4_u0_in_ready", 64'(g_u[0].bus.in_ready), 64'(!(c >= 5 && c <= 9)));
      if (c >= 5 && c <= 9) begin
        chk("t4_u0_stall_valid", 64'(g_u[0].bus.out_valid), 64'd1);
        chk("t4_u0_stall_dout", 64'(g_u[0].bus.dout), 64'd6);
        chk("t4_u0_stall_tag", 64'(g_u[0].bus.out_tag), 64'd2);
      end
      if (in_valid && g_u[0].bus.in_ready) b++;
    end
    chk("t4_u0_accepted", 64'(b), 64'd16);
    idle(10);

    // Reset with 3 beats in flight, then a fresh beat 2*3.
    for (int c = 0; c < 3; c++) begin
      cyc();
      out_ready = 1'b0;
      in_valid = 1'b1; din0 = 14'(10 + c); din1 = 12'd11; in_tag = 4'(1 + c);
    end
    cyc();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; din0 = 14'd2; din1 = 12'd3; in_tag = 4'd9;
    @(negedge clk);
    chk("t5_u0_out_valid", 64'(g_u[0].bus.out_valid), 64'd0);
    chk("t5_u0_dout", 64'(g_u[0].bus.dout), 64'd0);
    chk("t5_u0_out_tag", 64'(g_u[0].bus.out_tag), 64'd0);
    chk("t5_u0_in_ready", 64'(g_u[0].bus.in_ready), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_u0_new_valid", 64'(g_u[0].bus.out_valid), 64'(k == 3));
      if (k == 3) begin
        chk("t5_u0_new_dout", 64'(g_u[0].bus.dout), 64'd6);
        chk("t5_u0_new_tag", 64'(g_u[0].bus.out_tag), 64'd9);
      end
    end
    idle(8);

    // Random traffic, 50% in_valid and 50% out_ready.
    for (int c = 0; c < 25000; c++) begin
      cyc();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      din0      = 14'($urandom);
      din1      = 12'($urandom);
      in_tag    = 4'($urandom);
    end
    idle(12);

    drain_chk = 1'b1;
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
